hex_counter: RTL and testbench
==============================

HEX_COUNTER -- requirements
Module: hex_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000: clock cycles per 1 Hz tick; benches override with a small value.
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port enable  input  1  1 = divider and counter advance; 0 = hold.
REQ-005 The block SHALL have port speed  input  2  tick period select: 00 = every cycle, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles.
REQ-006 The block SHALL have port load  input  1  synchronous parallel load of the count.
REQ-007 The block SHALL have port load_val  input  4  value taken on load.
REQ-008 The block SHALL have port q  output  4  current hex digit, fed directly to the downstream 7-segment decoder's 4-bit input.
REQ-009 The block SHALL have port tick  output  1  one-cycle pulse, high in the cycle q increments.

Function
REQ-010 The block SHALL hold a down-counter rd, wide enough for 4*CLK_HZ-1 (28 bits at the default), and a registered copy speed_q of speed.
REQ-011 The period P SHALL be 1, CLK_HZ, 2*CLK_HZ or 4*CLK_HZ per speed_q; the reload value SHALL be P-1.
REQ-012 tick SHALL be combinational: tick = enable & resetn & ~load & (speed == speed_q) & (rd == 0).
REQ-013 On an edge with tick=1, q SHALL become q+1 modulo 16 (F wraps to 0) and rd SHALL load P-1.
REQ-014 On an edge with enable=1 and tick=0 (no load, no speed change), rd SHALL decrement by 1.
REQ-015 With enable=0 (no load, no speed change), rd and q SHALL hold and tick SHALL be 0.
REQ-016 With speed=00, tick SHALL be high on every enabled cycle, so q increments every cycle.
REQ-017 When speed != speed_q, on that edge speed_q SHALL take speed and rd SHALL load the new P-1; tick SHALL be 0 that cycle and q SHALL hold, independent of enable.
REQ-018 The next tick after a speed change SHALL occur after P further enabled cycles.
REQ-019 When load=1 (resetn high), q SHALL take load_val and rd SHALL load P-1 for the current speed.
REQ-020 With load=1, tick SHALL be 0 and q SHALL not increment, regardless of enable.
REQ-021 load SHALL take priority over a simultaneous speed change; speed_q SHALL still update.
REQ-022 Priority SHALL be: reset > load > speed change > tick > decrement > hold.
REQ-023 q SHALL be a direct register output with no combinational path from any input to q; it changes only on clock edges.

Reset
REQ-024 On an edge with resetn=0, q SHALL become 0, rd SHALL become 0 and speed_q SHALL take the current speed.
REQ-025 While resetn=0, tick SHALL be 0.
REQ-026 Reset mid-count SHALL discard divider progress, so the first enabled cycle after release with an unchanged speed ticks.
REQ-027 No output SHALL be X after the first reset edge.

Verification (CLK_HZ=4)
REQ-028 Reset; speed=00, enable=1 for 20 cycles -> q = 0,1,..,F,0,1,2,3; tick high every cycle; wrap F->0 seen.
REQ-029 Reset; speed=01, enable=1 -> tick on cycles 1, 5 and 9 after release; q = 1, 2, 3 after those edges.
REQ-030 speed=11 mid-count at q=2 -> no tick for 16 enabled cycles after the change edge, then q=3.
REQ-031 enable=0 for 10 cycles with rd=2 -> q and rd frozen; after re-enable, tick on the 3rd enabled cycle.
REQ-032 load=1, load_val=E coinciding with rd==0 and enable=1 -> q=E, no tick; after 4 enabled cycles (speed 01) q=F, after 4 more q=0.
REQ-033 resetn=0 for 1 cycle while q=9 and rd=3 -> q=0, tick=0 during reset, tick on the first enabled cycle after release.

Source files
------------

// File: rtl/hex_counter.sv
// hex_counter: free-running hex digit (0..F) advanced by a programmable
// tick divider. A down-counter rd counts enabled cycles; when it reaches
// zero the digit increments and rd reloads with (period - 1).
//
// Ports
//   clock     sole clock, rising edge
//   resetn    synchronous active-low reset
//   enable    1 = divider and digit advance, 0 = hold
//   speed     tick period: 00 = 1, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles
//   load      synchronous parallel load of the digit
//   load_val  digit value taken on load
//   q         current hex digit (direct register output)
//   tick      one-cycle pulse, high in the cycle q increments
module hex_counter #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       tick
);

  localparam int RD_W = (4 * CLK_HZ > 1) ? $clog2(4 * CLK_HZ) : 1;

  localparam logic [RD_W-1:0] RELOAD_1X = RD_W'(CLK_HZ - 1);
  localparam logic [RD_W-1:0] RELOAD_2X = RD_W'(2 * CLK_HZ - 1);
  localparam logic [RD_W-1:0] RELOAD_4X = RD_W'(4 * CLK_HZ - 1);

  logic [3:0]      count_q, count_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [1:0]      speed_q, speed_d;
  logic            speed_change;
  logic            tick_w;

  function automatic logic [RD_W-1:0] reload_for(input logic [1:0] s);
    logic [RD_W-1:0] r;
    case (s)
      2'b00:   r = '0;
      2'b01:   r = RELOAD_1X;
      2'b10:   r = RELOAD_2X;
      default: r = RELOAD_4X;
    endcase
    return r;
  endfunction

  // A speed change restarts the divider on the new period, so the first
  // cycle at the new speed must not tick even if rd happens to be zero.
  assign speed_change = (speed != speed_q);
  assign tick_w       = enable & resetn & ~load & ~speed_change & (rd_q == '0);

  always_comb begin
    speed_d = speed;
    count_d = count_q;
    rd_d    = rd_q;
    if (load) begin
      count_d = load_val;
      rd_d    = reload_for(speed);
    end else if (speed_change) begin
      rd_d    = reload_for(speed);
    end else if (tick_w) begin
      count_d = count_q + 4'd1;
      rd_d    = reload_for(speed_q);
    end else if (enable) begin
      rd_d    = rd_q - RD_W'(1);
    end
  end

  // Reset clears rd to zero (not to a reload value) so the first enabled
  // cycle after release ticks immediately.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= 4'd0;
      rd_q    <= '0;
      speed_q <= speed;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      speed_q <= speed_d;
    end
  end

  assign q    = count_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_hex_counter.sv
// tb_hex_counter: checks hex_counter (CLK_HZ = 4) against a behavioural
// model of the digit and "enabled cycles left before the next tick",
// with directed scenarios pinned by literal expectations and a random phase.
module tb_hex_counter;

  localparam int CLK_HZ = 4;

  logic       clock;
  logic       resetn;
  logic       enable;
  logic [1:0] speed;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tick;

  int checks;
  int errors;

  // behavioural model state
  int         m_q;
  int         m_left;
  logic [1:0] m_spd;
  bit         armed;
  logic       last_tick;

  hex_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .speed    (speed),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tick     (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int period(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, then
  // advance the model on the rising edge using the same inputs.
  task automatic step(input logic en, input logic [1:0] spd, input logic ld,
                      input logic [3:0] lv, input logic rn);
    logic exp_tick;
    enable   = en;
    speed    = spd;
    load     = ld;
    load_val = lv;
    resetn   = rn;
    @(negedge clock);
    last_tick = tick;
    if (armed) begin
      exp_tick = rn && en && !ld && (spd == m_spd) && (m_left == 0);
      chk("model_q", q, 4'(m_q));
      chk("model_tick", {3'b0, tick}, {3'b0, exp_tick});
    end
    @(posedge clock);
    if (!rn) begin
      m_q    = 0;
      m_left = 0;
      m_spd  = spd;
      armed  = 1'b1;
    end else if (ld) begin
      m_q    = int'(lv);
      m_left = period(spd) - 1;
      m_spd  = spd;
    end else if (spd != m_spd) begin
      m_spd  = spd;
      m_left = period(spd) - 1;
    end else if (en) begin
      if (m_left == 0) begin
        m_q    = (m_q + 1) % 16;
        m_left = period(spd) - 1;
      end else begin
        m_left = m_left - 1;
      end
    end
    #1;
  endtask

  logic [1:0] r_spd;

  initial begin
    checks   = 0;
    errors   = 0;
    armed    = 1'b0;
    m_q      = 0;
    m_left   = 0;
    m_spd    = 2'b00;
    enable   = 1'b0;
    speed    = 2'b00;
    load     = 1'b0;
    load_val = 4'h0;
    resetn   = 1'b0;
    @(posedge clock);
    #1;

    // Fastest speed: increments every cycle, wraps F -> 0
    step(1'b0, 2'b00, 1'b0, 4'h0, 1'b0);
    chk("reset_q", q, 4'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'b00, 1'b0, 4'h0, 1'b1);
      chk("fast_tick", {3'b0, last_tick}, 4'h1);
      if (i == 14) chk("fast_q_F", q, 4'hF);
      if (i == 15) chk("fast_wrap_0", q, 4'h0);
    end
    chk("fast_q_end", q, 4'h4);

    // Speed 01 from reset: ticks on cycles 1, 5, 9
    step(1'b0, 2'b01, 1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
      if (i == 1) begin
        chk("s1_tick_c1", {3'b0, last_tick}, 4'h1);
        chk("s1_q_c1", q, 4'h1);
      end
      if (i == 4) chk("s1_notick_c4", {3'b0, last_tick}, 4'h0);
      if (i == 5) begin
        chk("s1_tick_c5", {3'b0, last_tick}, 4'h1);
        chk("s1_q_c5", q, 4'h2);
      end
    end

    // Change to speed 11 at q=2: 16 enabled cycles to next tick
    step(1'b1, 2'b11, 1'b0, 4'h0, 1'b1);
    chk("chg_notick", {3'b0, last_tick}, 4'h0);
    chk("chg_q_hold", q, 4'h2);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b11, 1'b0, 4'h0, 1'b1);
      if (i == 14) chk("s3_q_before", q, 4'h2);
      if (i == 15) begin
        chk("s3_tick_16", {3'b0, last_tick}, 4'h1);
        chk("s3_q_after", q, 4'h3);
      end
    end

    // Hold with rd=2, then tick on the 3rd enabled cycle
    step(1'b0, 2'b01, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b01, 1'b0, 4'h0, 1'b1);
      chk("hold_notick", {3'b0, last_tick}, 4'h0);
    end
    chk("hold_q", q, 4'h1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
      if (i == 2) chk("reen_notick_2", {3'b0, last_tick}, 4'h0);
      if (i == 3) chk("reen_tick_3", {3'b0, last_tick}, 4'h1);
    end
    chk("reen_q", q, 4'h2);

    // Load E while rd==0 and enabled: no tick, then F, then 0
    step(1'b0, 2'b01, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b01, 1'b1, 4'hE, 1'b1);
    chk("load_notick", {3'b0, last_tick}, 4'h0);
    chk("load_q", q, 4'hE);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    chk("load_q_F", q, 4'hF);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    chk("load_q_0", q, 4'h0);

    // Reset mid-count with q=9, rd=3
    step(1'b1, 2'b01, 1'b1, 4'h9, 1'b1);
    chk("pre_rst_q", q, 4'h9);
    step(1'b1, 2'b01, 1'b0, 4'h0, 1'b0);
    chk("rst_notick", {3'b0, last_tick}, 4'h0);
    chk("rst_q", q, 4'h0);
    step(1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    chk("post_rst_tick", {3'b0, last_tick}, 4'h1);
    chk("post_rst_q", q, 4'h1);

    // Random phase against the model
    r_spd = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) r_spd = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           r_spd,
           ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
